// File: rtl/data_bus_bridge_pkg.sv
// Shared definitions for the data bus bridge: FSM encodings, kseg mapping
// constants and bus size codes.
package data_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  // addr[31:30] value selecting kseg0/kseg1; mapping clears addr[31:29]
  localparam logic [1:0] KSEG_TOP = 2'b10;
  localparam logic [2:0] KSEG_CLR = 3'b000;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic is_kseg01(input logic [31:0] vaddr);
    return vaddr[31:30] == KSEG_TOP;
  endfunction

endpackage

// File: rtl/mem_addr_map.sv
// Virtual-to-physical address mapping for the data bus (combinational).
module mem_addr_map
  import data_bus_bridge_pkg::*;
#(
  parameter int KSEG_MAP = 1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  // kseg0/kseg1 fold onto physical space by clearing the top three bits
  always_comb begin
    paddr = vaddr;
    if ((KSEG_MAP != 0) && is_kseg01(vaddr)) begin
      paddr = {KSEG_CLR, vaddr[28:0]};
    end
  end

endmodule

// File: rtl/data_bus_bridge.sv
// Bridge between the memory-access stage and a split addr_ok/data_ok bus.
// Handshake: a request is issued while data_req=1 and accepted in the cycle
// data_addr_ok=1; once issued it is never withdrawn. data_data_ok=1 in WAIT
// completes it. Only one transaction is ever outstanding.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int KSEG_MAP = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_address,
  input  logic [31:0] write_mem_data,
  input  logic        pipe_allowin,
  input  logic        flush,
  output logic [31:0] read_mem_data,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  bridge_state_t state;
  logic          cancel;
  logic          req_wr;
  logic [1:0]    req_size;
  logic [3:0]    req_wstrb;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   rdata_r;
  logic          issue;
  logic          in_idle;
  logic [31:0]   sel_addr;

  assign in_idle = (state == IDLE);
  assign issue   = in_idle && mem_req && !flush && !cancel;

  // In IDLE the request goes out from live inputs; afterwards from latches
  always_comb begin
    data_wr    = req_wr;
    data_size  = req_size;
    data_wstrb = req_wstrb;
    sel_addr   = req_addr;
    data_wdata = req_wdata;
    if (in_idle) begin
      data_wr    = mem_wr;
      data_size  = mem_size;
      data_wstrb = mem_wstrb;
      sel_addr   = mem_address;
      data_wdata = write_mem_data;
    end
  end

  mem_addr_map #(
    .KSEG_MAP (KSEG_MAP)
  ) u_addr_map (
    .vaddr (sel_addr),
    .paddr (data_addr)
  );

  // Request and stall are forced low while reset is asserted
  always_comb begin
    data_req  = resetn && (issue || (state == REQ));
    mem_stall = resetn && ((in_idle && mem_req) || (state == REQ) ||
                           (state == WAIT) || cancel);
  end

  assign read_mem_data = rdata_r;

  // Transaction FSM with request latches, cancel flag and read-data register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cancel    <= 1'b0;
      req_wr    <= 1'b0;
      req_size  <= 2'b00;
      req_wstrb <= 4'h0;
      req_addr  <= 32'h0;
      req_wdata <= 32'h0;
      rdata_r   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            req_wr    <= mem_wr;
            req_size  <= mem_size;
            req_wstrb <= mem_wstrb;
            req_addr  <= mem_address;
            req_wdata <= write_mem_data;
            state     <= data_addr_ok ? WAIT : REQ;
          end
        end
        REQ: begin
          if (flush) cancel <= 1'b1;
          if (data_addr_ok) state <= WAIT;
        end
        WAIT: begin
          if (data_data_ok) begin
            if (cancel || flush) begin
              // cancelled transaction drains without reaching the stage
              cancel <= 1'b0;
              state  <= IDLE;
            end else begin
              rdata_r <= data_rdata;
              state   <= DONE;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        DONE: begin
          if (flush || pipe_allowin) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_bus_bridge.md
DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 Parameter KSEG_MAP, default 1, SHALL enable kseg0/kseg1 (addr[31:30]==2'b10) to physical mapping by clearing addr[31:29].
REQ-002 Port list SHALL be exactly:
- clk  in  1  sole clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- mem_req  in  1  memory access request from the memory-access stage.
- mem_wr  in  1  1 = store, 0 = load.
- mem_size  in  2  00 byte, 01 half, 10 word.
- mem_wstrb  in  4  store byte enables.
- mem_address  in  32  virtual byte address.
- write_mem_data  in  32  store data, already lane-aligned.
- pipe_allowin  in  1  next pipeline register accepts this cycle.
- flush  in  1  exception/eret flush of the memory-access stage.
- read_mem_data  out  32  load data returned to the stage.
- mem_stall  out  1  stage SHALL hold its inputs while high.
- data_req  out  1  bus request.
- data_wr, data_size[1:0], data_wstrb[3:0], data_addr[31:0], data_wdata[31:0]  out  bus request fields.
- data_addr_ok  in  1  bus accepted request.
- data_data_ok  in  1  bus returned data / write acknowledge.
- data_rdata  in  32  bus read data.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE, encoded 2'd0..2'd3.
REQ-004 In IDLE with mem_req=1 and flush=0, data_req SHALL be 1 in that cycle, driven from live inputs; the fields SHALL also be latched into request registers.
REQ-005 IDLE transitions: addr_ok=1 -> WAIT; addr_ok=0 -> REQ; mem_req=0 -> stay.
REQ-006 In REQ, data_req SHALL be 1 with latched fields, held until data_addr_ok, then -> WAIT.
REQ-007 data_addr SHALL be the mapped address per REQ-001; other fields SHALL pass unchanged.
REQ-008 In WAIT, data_data_ok=1 SHALL latch data_rdata into the read-data register and go to DONE; data_data_ok asserted in the same cycle as data_addr_ok SHALL be ignored.
REQ-009 In DONE, read_mem_data SHALL equal the latched data; pipe_allowin=1 -> IDLE, else stay.
REQ-010 mem_stall SHALL be 1 for: IDLE with mem_req; REQ; WAIT (including the data_ok cycle); any cycle with cancel=1. It SHALL be 0 in DONE and in idle IDLE.
REQ-011 Minimum load/store latency: addr_ok in cycle T, data_ok in T+1, DONE with stall=0 in T+2.
REQ-012 Flush in IDLE SHALL suppress data_req. Flush in REQ or WAIT SHALL set cancel; the outstanding transaction SHALL complete on the bus, since requests are never withdrawn. Data_ok with cancel SHALL go to IDLE without entering DONE and clear cancel. Flush in DONE SHALL go to IDLE.
REQ-013 With cancel=1, a new mem_req SHALL not be issued until cancel clears.
REQ-014 Only one transaction SHALL be outstanding at any time.

Reset
REQ-015 On resetn=0, asynchronously: state=IDLE, cancel=0, request registers=0, read-data register=32'h0.
REQ-016 During reset: data_req=0, mem_stall=0, read_mem_data=32'h0.
REQ-017 Reset mid-transaction SHALL abandon it; no replay after release.

Structure
REQ-018 FSM state encodings, KSEG constants and size codes (BYTE/HALF/WORD) SHALL live in the shared defs header.
REQ-019 Address mapping SHALL be a sub-module mem_addr_map (combinational, parameter KSEG_MAP).
REQ-020 Target size: 150-250 lines of RTL.

Verification
REQ-021 Word load addr 0x8000_1000: addr_ok T, data_ok T+1 with rdata 0xDEADBEEF. Required: data_addr=0x0000_1000; stall=1 at T and T+1; T+2 read_mem_data=0xDEADBEEF with stall=0.
REQ-022 Byte store addr 0xA000_0003, wstrb 4'b1000, addr_ok delayed 3 cycles. Required: data_req held 4 cycles with fields constant; data_addr=0x0000_0003.
REQ-023 Flush during WAIT, then data_ok. Required: no DONE; stall=1 until data_ok; next mem_req issued the cycle after.
REQ-024 DONE with pipe_allowin=0 for 2 cycles. Required: read_mem_data stable, no new data_req; IDLE after allowin=1.
REQ-025 resetn low during REQ. Required: data_req=0 and state IDLE immediately; no bus activity after release until mem_req.
